// File: rtl/calc_nport_core.sv
// calc_nport_core: N-port tagged two-cycle request calculator sharing one round-robin ALU.
// Optional macro CALC_DROP_CNT_EN adds per-port saturating rejected-push counters on drop_cnt.

module calc_nport_core #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*TAG_W-1:0]  out_tag,
  output logic [NUM_PORTS-1:0]        out_busy
`ifdef CALC_DROP_CNT_EN
  ,
  output logic [NUM_PORTS*8-1:0]      drop_cnt
`endif
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(DATA_W);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'b01;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_OP2 = 1'b1} cap_state_t;

  entry_t                 head [NUM_PORTS];
  logic [NUM_PORTS-1:0]   nonempty;
  logic [NUM_PORTS-1:0]   busy_d;
  logic [NUM_PORTS-1:0]   pop;
  logic [PW-1:0]          rr_q;
  logic [PW-1:0]          cand;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_vld;

  // Round-robin grant: first nonempty FIFO at or after the search start rr_q
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    pop     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (!gnt_vld && nonempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      rr_q <= '0;
    end else if (gnt_vld) begin
      rr_q <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Shared ALU on the head entry of the granted port
  entry_t            g_ent;
  logic [DATA_W:0]   sum;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  always_comb begin
    g_ent    = head[gnt_idx];
    sum      = {1'b0, g_ent.op1} + {1'b0, g_ent.op2};
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (g_ent.cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (g_ent.op2 <= g_ent.op1) begin
          alu_resp = RESP_OK;
          alu_data = g_ent.op1 - g_ent.op2;
        end
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = g_ent.op1 << g_ent.op2[SW-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = g_ent.op1 >> g_ent.op2[SW-1:0];
      end
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [3:0]        cmd_in;
    logic [DATA_W-1:0] data_in;
    logic [TAG_W-1:0]  tag_in;
    cap_state_t        st_q, st_d;
    logic              push;
    logic              accept;
    logic [3:0]        cap_cmd;
    logic [DATA_W-1:0] cap_op1;
    logic [TAG_W-1:0]  cap_tag;
    entry_t            mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign cmd_in  = req_cmd_in[p*4 +: 4];
    assign data_in = req_data_in[p*DATA_W +: DATA_W];
    assign tag_in  = req_tag_in[p*TAG_W +: TAG_W];

    // Capture FSM: command cycle, then operand-2 cycle which pushes the request
    always_comb begin
      st_d = st_q;
      push = 1'b0;
      case (st_q)
        ST_IDLE: if (cmd_in != 4'd0) st_d = ST_OP2;
        ST_OP2: begin
          push = 1'b1;
          st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge c_clk) begin
      if (!reset) st_q <= ST_IDLE;
      else        st_q <= st_d;
    end

    always_ff @(posedge c_clk) begin
      if (!reset) begin
        cap_cmd <= '0;
        cap_op1 <= '0;
        cap_tag <= '0;
      end else if (st_q == ST_IDLE && cmd_in != 4'd0) begin
        cap_cmd <= cmd_in;
        cap_op1 <= data_in;
        cap_tag <= tag_in;
      end
    end

    // A full FIFO still accepts when its head leaves on the same edge
    assign accept = push && ((cnt_q != CW'(FIFO_DEPTH)) || pop[p]);
    assign cnt_d  = cnt_q + CW'(accept) - CW'(pop[p]);

    always_ff @(posedge c_clk) begin
      if (reset && accept) begin
        mem[wr_q] <= '{cmd: cap_cmd, op1: cap_op1, op2: data_in, tag: cap_tag};
      end
    end

    always_ff @(posedge c_clk) begin
      if (!reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (accept) wr_q <= wr_q + AW'(1);
        if (pop[p]) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_d;
      end
    end

    assign head[p]     = mem[rd_q];
    assign nonempty[p] = (cnt_q != '0);
    assign busy_d[p]   = (cnt_d == CW'(FIFO_DEPTH));

`ifdef CALC_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge c_clk) begin
      if (!reset) begin
        drop_q <= '0;
      end else if (push && !accept && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end

    assign drop_cnt[p*8 +: 8] = drop_q;
`endif
  end

  // Response registers: only the granted port carries a response for one cycle
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      out_busy <= '0;
    end else begin
      out_busy <= busy_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_resp[p*2 +: 2]           <= pop[p] ? alu_resp  : 2'b00;
        out_data[p*DATA_W +: DATA_W] <= pop[p] ? alu_data  : '0;
        out_tag[p*TAG_W +: TAG_W]    <= pop[p] ? g_ent.tag : '0;
      end
    end
  end

endmodule

// File: tb/tb_calc_nport_core.sv
// Bench for calc_nport_core: directed vector table, multi-cycle corner sequences,
// and random traffic checked every cycle against a queue-based reference model.

module tb_calc_nport_core;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  logic              c_clk;
  logic              reset;
  logic [NP*4-1:0]   cmd_v;
  logic [NP*DW-1:0]  data_v;
  logic [NP*TW-1:0]  tag_v;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic [NP*TW-1:0]  out_tag;
  logic [NP-1:0]     out_busy;
`ifdef CALC_DROP_CNT_EN
  logic [NP*8-1:0]   drop_cnt;
`endif

  calc_nport_core #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .TAG_W     (TW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (cmd_v),
    .req_data_in(data_v),
    .req_tag_in (tag_v),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_busy   (out_busy)
`ifdef CALC_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Reference model state: one queue per port plus a half-captured request
  typedef struct packed {
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [TW-1:0] tag;
  } req_t;

  req_t              mq [NP][$];
  req_t              pend_r [NP];
  bit                pend [NP];
  int                mdrop [NP];
  int                rr;
  logic [NP*2-1:0]   e_resp;
  logic [NP*DW-1:0]  e_data;
  logic [NP*TW-1:0]  e_tag;
  logic [NP-1:0]     e_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  function automatic void ref_alu(input req_t r, output logic [1:0] resp, output logic [DW-1:0] data);
    longint unsigned a, b, s;
    a = r.op1;
    b = r.op2;
    resp = 2'b10;
    data = '0;
    case (r.cmd)
      4'd1: begin
        s = a + b;
        if (s <= 64'hFFFF_FFFF) begin resp = 2'b01; data = DW'(s); end
      end
      4'd2: if (b <= a) begin resp = 2'b01; data = DW'(a - b); end
      4'd5: begin resp = 2'b01; data = DW'(a << (b % 32)); end
      4'd6: begin resp = 2'b01; data = DW'(a >> (b % 32)); end
      default: begin resp = 2'b10; data = '0; end
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  function automatic void model_step();
    int g;
    int c;
    req_t r;
    logic [1:0] rsp;
    logic [DW-1:0] dat;
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        pend[p]  = 1'b0;
        mdrop[p] = 0;
      end
      rr = 0;
      e_resp = '0; e_data = '0; e_tag = '0; e_busy = '0;
      return;
    end
    e_resp = '0; e_data = '0; e_tag = '0;
    g = -1;
    for (int i = 0; i < NP; i++) begin
      c = (rr + i) % NP;
      if (g < 0 && mq[c].size() > 0) g = c;
    end
    if (g >= 0) begin
      r = mq[g].pop_front();
      ref_alu(r, rsp, dat);
      e_resp[g*2 +: 2]  = rsp;
      e_data[g*DW +: DW] = dat;
      e_tag[g*TW +: TW] = r.tag;
      rr = (g + 1) % NP;
    end
    for (int p = 0; p < NP; p++) begin
      if (pend[p]) begin
        r = pend_r[p];
        r.op2 = data_v[p*DW +: DW];
        if (mq[p].size() < DEPTH) mq[p].push_back(r);
        else if (mdrop[p] < 255) mdrop[p]++;
        pend[p] = 1'b0;
      end else if (cmd_v[p*4 +: 4] != 4'd0) begin
        pend[p] = 1'b1;
        pend_r[p].cmd = cmd_v[p*4 +: 4];
        pend_r[p].op1 = data_v[p*DW +: DW];
        pend_r[p].op2 = '0;
        pend_r[p].tag = tag_v[p*TW +: TW];
      end
      e_busy[p] = (mq[p].size() == DEPTH);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge c_clk);
    #1;
    cyc++;
    n_vec++;
    if (out_resp !== e_resp || out_data !== e_data || out_tag !== e_tag || out_busy !== e_busy) begin
      n_err++;
      $display("FAIL model cycle %0d: got resp=%h tag=%h busy=%b data=%h, expected resp=%h tag=%h busy=%b data=%h",
               cyc, out_resp, out_tag, out_busy, out_data, e_resp, e_tag, e_busy, e_data);
    end
`ifdef CALC_DROP_CNT_EN
    for (int p = 0; p < NP; p++) chk($sformatf("drop_cnt p%0d", p), 64'(drop_cnt[p*8 +: 8]), 64'(mdrop[p]));
`endif
  endtask

  task automatic clear_in();
    cmd_v = '0; data_v = '0; tag_v = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_in();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] t);
    cmd_v[p*4 +: 4] = c; data_v[p*DW +: DW] = a; tag_v[p*TW +: TW] = t;
    tick();
    cmd_v[p*4 +: 4] = 4'd0; data_v[p*DW +: DW] = b;
    tick();
    data_v[p*DW +: DW] = '0; tag_v[p*TW +: TW] = '0;
  endtask

  typedef struct {
    int            port;
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [TW-1:0] tag;
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vt [11];

  initial begin
    int saw_busy;
    int p0_ok;
    int sel;
    logic [NP*2-1:0] exp_r;
    logic [DW-1:0] d;

    vt[0]  = '{0, 4'd1, 32'h30,          32'h20, 2'd1, 2'b01, 32'h50};
    vt[1]  = '{1, 4'd1, 32'hFFFF_FFFF,   32'h1,  2'd2, 2'b10, 32'h0};
    vt[2]  = '{1, 4'd2, 32'h5,           32'h7,  2'd3, 2'b10, 32'h0};
    vt[3]  = '{1, 4'd2, 32'h7,           32'h7,  2'd0, 2'b01, 32'h0};
    vt[4]  = '{2, 4'd5, 32'h1,           32'h21, 2'd1, 2'b01, 32'h2};
    vt[5]  = '{2, 4'd6, 32'h8000_0000,   32'd31, 2'd2, 2'b01, 32'h1};
    vt[6]  = '{2, 4'd3, 32'h4,           32'h4,  2'd3, 2'b10, 32'h0};
    vt[7]  = '{3, 4'd2, 32'd100,         32'd1,  2'd2, 2'b01, 32'd99};
    vt[8]  = '{3, 4'd5, 32'hF000_0000,   32'd4,  2'd1, 2'b01, 32'h0};
    vt[9]  = '{0, 4'd1, 32'hFFFF_FFFE,   32'h1,  2'd3, 2'b01, 32'hFFFF_FFFF};
    vt[10] = '{3, 4'hF, 32'h12,          32'h34, 2'd1, 2'b10, 32'h0};

    do_reset();
    chk("reset resp/tag/busy", 64'({out_resp, out_tag, out_busy}), 64'd0);
    chk("reset data", 64'(|out_data), 64'd0);

    // Directed vectors: response must appear right after edge E2+1, then clear
    for (int i = 0; i < 11; i++) begin
      issue(vt[i].port, vt[i].cmd, vt[i].op1, vt[i].op2, vt[i].tag);
      tick();
      chk($sformatf("vec%0d resp", i), 64'(out_resp[vt[i].port*2 +: 2]), 64'(vt[i].resp));
      chk($sformatf("vec%0d data", i), 64'(out_data[vt[i].port*DW +: DW]), 64'(vt[i].data));
      chk($sformatf("vec%0d tag", i), 64'(out_tag[vt[i].port*TW +: TW]), 64'(vt[i].tag));
      tick();
      chk($sformatf("vec%0d resp clear", i), 64'(out_resp), 64'd0);
    end

    // All ports issue together: answered on ports 0..3 in consecutive cycles
    do_reset();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p*4 +: 4] = 4'd1; data_v[p*DW +: DW] = DW'(16 * (p + 1)); tag_v[p*TW +: TW] = TW'(p);
    end
    tick();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p*4 +: 4] = 4'd0; data_v[p*DW +: DW] = DW'(p + 1);
    end
    tick();
    clear_in();
    for (int k = 0; k < NP; k++) begin
      tick();
      exp_r = '0;
      exp_r[k*2 +: 2] = 2'b01;
      chk($sformatf("allports resp k%0d", k), 64'(out_resp), 64'(exp_r));
      chk($sformatf("allports tag k%0d", k), 64'(out_tag[k*TW +: TW]), 64'(k));
      chk($sformatf("allports data k%0d", k), 64'(out_data[k*DW +: DW]), 64'(17 * (k + 1)));
    end
    tick();
    chk("allports done", 64'(out_resp), 64'd0);

    // Port 0 overfills while ports 1-3 keep arbitration saturated
    do_reset();
    saw_busy = 0;
    p0_ok = 0;
    for (int c = 0; c < 64; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (c < 24 && c % 2 == 0) begin
          cmd_v[p*4 +: 4] = 4'd1; data_v[p*DW +: DW] = DW'(32'h100 * (p + 1) + c);
          tag_v[p*TW +: TW] = TW'(c / 2);
        end else begin
          cmd_v[p*4 +: 4] = 4'd0; data_v[p*DW +: DW] = DW'(c);
        end
      end
      tick();
      if (out_busy[0]) saw_busy = 1;
      if (out_resp[1:0] == 2'b01) p0_ok++;
    end
    clear_in();
    chk("p0 busy seen", 64'(saw_busy), 64'd1);
    chk("p0 accepted responses", 64'(p0_ok), 64'd10);
`ifdef CALC_DROP_CNT_EN
    chk("p0 drop_cnt", 64'(drop_cnt[7:0]), 64'd2);
`endif

    // Reset between E1 and E2 with queued work: nothing emerges afterwards
    do_reset();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p*4 +: 4] = 4'd1; data_v[p*DW +: DW] = DW'(p + 10); tag_v[p*TW +: TW] = TW'(p);
    end
    tick();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p*4 +: 4] = 4'd0; data_v[p*DW +: DW] = DW'(1);
    end
    tick();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p*4 +: 4] = 4'd2; data_v[p*DW +: DW] = DW'(50);
    end
    tick();
    reset = 1'b0;
    clear_in();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post-reset quiet %0d", k), 64'({out_resp, out_tag, out_busy, 11'd0, |out_data}), 64'd0);
    end
    issue(0, 4'd1, 32'd2, 32'd3, 2'd2);
    tick();
    chk("post-reset add resp", 64'(out_resp[1:0]), 64'd1);
    chk("post-reset add data", 64'(out_data[DW-1:0]), 64'd5);
    chk("post-reset add tag", 64'(out_tag[TW-1:0]), 64'd2);

    // Random traffic with occasional resets, checked against the model each cycle
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int p = 0; p < NP; p++) begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          4: cmd_v[p*4 +: 4] = 4'd1;
          5: cmd_v[p*4 +: 4] = 4'd2;
          6: cmd_v[p*4 +: 4] = 4'd5;
          7: cmd_v[p*4 +: 4] = 4'd6;
          8: cmd_v[p*4 +: 4] = 4'($urandom_range(7, 15));
          9: cmd_v[p*4 +: 4] = 4'($urandom_range(3, 4));
          default: cmd_v[p*4 +: 4] = 4'd0;
        endcase
        case ($urandom_range(0, 4))
          0: d = $urandom;
          1: d = 32'hFFFF_FFFF;
          2: d = 32'h8000_0000;
          3: d = DW'($urandom_range(0, 40));
          default: d = $urandom;
        endcase
        data_v[p*DW +: DW] = d;
        tag_v[p*TW +: TW] = TW'($urandom_range(0, 3));
      end
      tick();
    end
    reset = 1'b1;
    clear_in();
    for (int n = 0; n < 30; n++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
